// File: rtl/fp_latency_tracker_if.sv
// fp_latency_tracker_if: request/core/result signal bundle for fp_latency_tracker
//   clk_en/dataa/tag_in   : start request, operand and tag
//   core_en/core_data     : clock enable and operand to the wrapped core
//   core_result           : result coming back from the wrapped core
//   result/tag_out/done   : registered result, its tag and one-cycle done pulse
//   busy/inflight         : request would be rejected / outstanding op count
//   reject_err            : sticky flag for a dropped request
interface fp_latency_tracker_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 2
);
    logic             clk_en;
    logic [WIDTH-1:0] dataa;
    logic [TAG_W-1:0] tag_in;
    logic             core_en;
    logic [WIDTH-1:0] core_data;
    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    logic             done;
    logic             busy;
    logic [6:0]       inflight;
    logic             reject_err;

    modport master (
        output clk_en, dataa, tag_in, core_result,
        input  core_en, core_data, result, tag_out, done, busy, inflight, reject_err
    );

    modport slave (
        input  clk_en, dataa, tag_in, core_result,
        output core_en, core_data, result, tag_out, done, busy, inflight, reject_err
    );
endinterface

// File: rtl/fp_latency_tracker.sv
// fp_latency_tracker: valid/tag tracking wrapper around a fixed-latency core
//   clock : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : request, core and result signals (see fp_latency_tracker_if)
module fp_latency_tracker #(
    parameter int WIDTH     = 32,
    parameter int LATENCY   = 17,
    parameter int TAG_W     = 2,
    parameter int PIPELINED = 0
) (
    input logic                  clock,
    input logic                  reset,
    fp_latency_tracker_if.slave  bus
);
    logic [LATENCY-1:0]         vld_q, vld_d;
    logic [LATENCY*TAG_W-1:0]   tag_q, tag_d;
    logic [LATENCY:0]           vld_ext;
    logic [(LATENCY+1)*TAG_W-1:0] tag_ext;
    logic [6:0]                 inflight_q, inflight_d;
    logic [WIDTH-1:0]           result_q, result_d;
    logic [TAG_W-1:0]           tag_out_q, tag_out_d;
    logic                       done_q, done_d;
    logic                       rej_q, rej_d;
    logic                       busy, accept, core_en, fire;

    always_comb begin
        busy       = (PIPELINED != 0) ? 1'b0 : (inflight_q != 7'd0);
        accept     = bus.clk_en & ~busy;
        core_en    = accept | (inflight_q != 7'd0);
        fire       = vld_q[LATENCY-1];
        // stage 0 takes the new accept flag/tag; the oldest stage falls off the top
        vld_ext    = {vld_q, accept};
        tag_ext    = {tag_q, bus.tag_in};
        vld_d      = core_en ? vld_ext[LATENCY-1:0] : vld_q;
        tag_d      = core_en ? tag_ext[LATENCY*TAG_W-1:0] : tag_q;
        inflight_d = inflight_q + 7'(accept) - 7'(fire);
        done_d     = fire;
        result_d   = fire ? bus.core_result : result_q;
        tag_out_d  = fire ? tag_q[LATENCY*TAG_W-1 -: TAG_W] : tag_out_q;
        rej_d      = rej_q | (bus.clk_en & busy);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            result_q   <= '0;
            tag_out_q  <= '0;
            done_q     <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            result_q   <= result_d;
            tag_out_q  <= tag_out_d;
            done_q     <= done_d;
            rej_q      <= rej_d;
        end
    end

    assign bus.core_en    = core_en;
    assign bus.core_data  = bus.dataa;
    assign bus.result     = result_q;
    assign bus.tag_out    = tag_out_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy;
    assign bus.inflight   = inflight_q;
    assign bus.reject_err = rej_q;
endmodule

// File: tb/tb_fp_latency_tracker.sv
// tb_fp_latency_tracker: directed self-checking bench for fp_latency_tracker
//   dut_a: LATENCY=17 blocking, dut_b: LATENCY=4 pipelined, dut_c: LATENCY=1 pipelined
module tb_fp_latency_tracker;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc = '0;
    logic [31:0] cr;
    logic [31:0] prev_cr = '0;
    logic [31:0] exp_res = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          infl_b [11] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 0, 0};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 32'd1;
    // core result changes every cycle so the sampling cycle is observable
    assign cr = 32'hC0DE0000 ^ cyc;

    fp_latency_tracker_if #(.WIDTH(32), .TAG_W(2)) ia ();
    fp_latency_tracker_if #(.WIDTH(32), .TAG_W(2)) ib ();
    fp_latency_tracker_if #(.WIDTH(32), .TAG_W(2)) ic ();

    assign ia.core_result = cr;
    assign ib.core_result = cr;
    assign ic.core_result = cr;

    fp_latency_tracker #(.WIDTH(32), .LATENCY(17), .TAG_W(2), .PIPELINED(0)) dut_a (
        .clock(clock), .reset(reset), .bus(ia));
    fp_latency_tracker #(.WIDTH(32), .LATENCY(4), .TAG_W(2), .PIPELINED(1)) dut_b (
        .clock(clock), .reset(reset), .bus(ib));
    fp_latency_tracker #(.WIDTH(32), .LATENCY(1), .TAG_W(2), .PIPELINED(1)) dut_c (
        .clock(clock), .reset(reset), .bus(ic));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        prev_cr = cr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        ia.clk_en = 1'b0; ia.dataa = '0; ia.tag_in = '0;
        ib.clk_en = 1'b0; ib.dataa = '0; ib.tag_in = '0;
        ic.clk_en = 1'b0; ic.dataa = '0; ic.tag_in = '0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clock);
        chk("rst_done_a", ia.done, 0);
        chk("rst_infl_a", ia.inflight, 0);
        chk("rst_busy_a", ia.busy, 0);
        chk("rst_coreen_a", ia.core_en, 0);
        chk("rst_result_a", ia.result, 0);
        chk("rst_tag_a", ia.tag_out, 0);
        chk("rst_rej_a", ia.reject_err, 0);
        chk("rst_infl_b", ib.inflight, 0);
        chk("rst_done_c", ic.done, 0);
        step();

        // blocking single op then back-to-back accept in the done cycle
        for (int c = 0; c <= 40; c++) begin
            logic inf;
            ia.clk_en = (c == 0 || c == 18);
            ia.dataa  = (c == 0) ? 32'h3F800000 : 32'h40000000;
            ia.tag_in = (c == 0) ? 2'd2 : 2'd1;
            inf = (c >= 1 && c <= 17) || (c >= 19 && c <= 35);
            @(negedge clock);
            if (c == 0) chk("a_core_data", ia.core_data, 32'h3F800000);
            chk("a_done", ia.done, (c == 18 || c == 36));
            chk("a_inflight", ia.inflight, inf);
            chk("a_busy", ia.busy, inf);
            chk("a_core_en", ia.core_en, inf || c == 0 || c == 18);
            if (c == 18 || c == 36) exp_res = prev_cr;
            if (c >= 18) chk("a_result", ia.result, exp_res);
            if (c >= 18 && c < 36) chk("a_tag1", ia.tag_out, 2);
            if (c >= 36) chk("a_tag2", ia.tag_out, 1);
            chk("a_rej", ia.reject_err, 0);
            step();
        end

        // blocking reject
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            ia.clk_en = (c == 0 || c == 5);
            ia.tag_in = (c == 0) ? 2'd3 : 2'd0;
            @(negedge clock);
            chk("b_done", ia.done, c == 18);
            chk("b_inflight", ia.inflight, (c >= 1 && c <= 17));
            chk("b_rej", ia.reject_err, c >= 6);
            if (c == 18) chk("b_tag", ia.tag_out, 3);
            step();
        end
        do_reset();
        @(negedge clock);
        chk("b_rej_clr", ia.reject_err, 0);
        step();

        // reset mid-flight, then a fresh op
        for (int c = 0; c <= 60; c++) begin
            logic inf;
            reset     = (c == 8);
            ia.clk_en = (c == 0 || c == 41);
            ia.tag_in = (c == 41) ? 2'd3 : 2'd2;
            inf = (c >= 1 && c <= 8) || (c >= 42 && c <= 58);
            @(negedge clock);
            chk("c_done", ia.done, c == 59);
            chk("c_inflight", ia.inflight, inf);
            chk("c_core_en", ia.core_en, inf || c == 0 || c == 41);
            if (c == 59) begin
                chk("c_tag", ia.tag_out, 3);
                chk("c_result", ia.result, prev_cr);
            end
            step();
        end
        reset = 1'b0;

        // reset wins over a simultaneous request
        reset = 1'b1;
        ib.clk_en = 1'b1;
        step();
        reset = 1'b0;
        ib.clk_en = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clock);
            chk("r_done", ib.done, 0);
            chk("r_inflight", ib.inflight, 0);
            step();
        end

        // pipelined burst, LATENCY=4
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            ib.clk_en = (c <= 2);
            ib.tag_in = 2'(c);
            @(negedge clock);
            chk("d_done", ib.done, (c >= 5 && c <= 7));
            chk("d_inflight", ib.inflight, infl_b[c]);
            chk("d_core_en", ib.core_en, c <= 6);
            chk("d_busy", ib.busy, 0);
            if (c >= 5 && c <= 7) begin
                chk("d_tag", ib.tag_out, c - 5);
                chk("d_result", ib.result, prev_cr);
            end
            step();
        end

        // minimum latency, LATENCY=1, continuous stream
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            ic.clk_en = (c <= 9);
            ic.tag_in = 2'(c);
            @(negedge clock);
            chk("e_done", ic.done, (c >= 2 && c <= 11));
            chk("e_inflight", ic.inflight, (c >= 1 && c <= 10));
            if (c >= 2 && c <= 11) begin
                chk("e_tag", ic.tag_out, (c - 2) % 4);
                chk("e_result", ic.result, prev_cr);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
